radix_4_div_ctrl: RTL and testbench



---
 rtl/radix_4_div_ctrl_if.sv | 25 ++
 rtl/radix_4_div_ctrl.sv | 173 +++++++++++++++++
 tb/tb_radix_4_div_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/radix_4_div_ctrl_if.sv
// Start/finish handshake bundle between the divider client and radix_4_div_ctrl.
//   master: client side (offers operations, accepts results)
//   slave : controller side (accepts operations, returns corrected quotient)
interface radix_4_div_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH / 2 + 1)
) ();
    logic             start_valid_i;
    logic             start_ready_o;
    logic             divisor_is_zero_i;
    logic [CNT_W-1:0] iter_num_i;
    logic             finish_valid_o;
    logic             finish_ready_i;
    logic [WIDTH-1:0] quot_o;

    modport master (
        output start_valid_i, divisor_is_zero_i, iter_num_i, finish_ready_i,
        input  start_ready_o, finish_valid_o, quot_o
    );

    modport slave (
        input  start_valid_i, divisor_is_zero_i, iter_num_i, finish_ready_i,
        output start_ready_o, finish_valid_o, quot_o
    );
endinterface

// File: rtl/radix_4_div_ctrl.sv
// Sequencing controller for the radix-4 SRT integer divider.
// Walks IDLE -> PRE -> ITER (iter_num cycles) -> POST -> DONE, performs
// on-the-fly quotient conversion from the one-hot digit each ITER cycle and
// selects Q or QM in POST from the final remainder sign.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       start valid/ready + operands, finish valid/ready + quot_o
//   quot_dig_i        one-hot digit {+2,+1,0,-1,-2}, consumed in ITER
//   rem_neg_i         final remainder sign, consumed in POST
//   pre_en_o/iter_en_o/post_en_o  datapath phase enables
module radix_4_div_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    radix_4_div_ctrl_if.slave    bus,
    input  logic [4:0]           quot_dig_i,
    input  logic                 rem_neg_i,
    output logic                 pre_en_o,
    output logic                 iter_en_o,
    output logic                 post_en_o
);
    localparam int unsigned HALF = WIDTH / 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ITER = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] iter_lat;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qm;
    logic [WIDTH-1:0] quot;
    logic             finish_valid;
    logic             pre_en;
    logic             iter_en;
    logic             post_en;

    logic [CNT_W-1:0] iter_sat_c;
    logic [WIDTH-1:0] q_nxt_c;
    logic [WIDTH-1:0] qm_nxt_c;

    assign bus.start_ready_o  = (state == IDLE);
    assign bus.finish_valid_o = finish_valid;
    assign bus.quot_o         = quot;
    assign pre_en_o           = pre_en;
    assign iter_en_o          = iter_en;
    assign post_en_o          = post_en;

    // Clamp requested iteration count into 1..WIDTH/2.
    always_comb begin
        iter_sat_c = bus.iter_num_i;
        if (bus.iter_num_i == '0) begin
            iter_sat_c = CNT_W'(1);
        end else if (32'(bus.iter_num_i) > 32'(HALF)) begin
            iter_sat_c = CNT_W'(HALF);
        end
    end

    // On-the-fly conversion; anything not one-hot behaves as digit 0.
    always_comb begin
        q_nxt_c  = {q[WIDTH-3:0], 2'b00};
        qm_nxt_c = {qm[WIDTH-3:0], 2'b11};
        case (quot_dig_i)
            5'b10000: begin
                q_nxt_c  = {q[WIDTH-3:0], 2'b10};
                qm_nxt_c = {q[WIDTH-3:0], 2'b01};
            end
            5'b01000: begin
                q_nxt_c  = {q[WIDTH-3:0], 2'b01};
                qm_nxt_c = {q[WIDTH-3:0], 2'b00};
            end
            5'b00010: begin
                q_nxt_c  = {qm[WIDTH-3:0], 2'b11};
                qm_nxt_c = {qm[WIDTH-3:0], 2'b10};
            end
            5'b00001: begin
                q_nxt_c  = {qm[WIDTH-3:0], 2'b10};
                qm_nxt_c = {qm[WIDTH-3:0], 2'b01};
            end
            default: begin
                q_nxt_c  = {q[WIDTH-3:0], 2'b00};
                qm_nxt_c = {qm[WIDTH-3:0], 2'b11};
            end
        endcase
    end

    // Phase sequencer; enables and finish flag are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            iter_lat     <= '0;
            cnt          <= '0;
            q            <= '0;
            qm           <= '0;
            quot         <= '0;
            finish_valid <= 1'b0;
            pre_en       <= 1'b0;
            iter_en      <= 1'b0;
            post_en      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid_i) begin
                        iter_lat <= iter_sat_c;
                        if (bus.divisor_is_zero_i) begin
                            quot         <= '1;
                            finish_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            pre_en <= 1'b1;
                            state  <= PRE;
                        end
                    end
                end
                PRE: begin
                    cnt     <= iter_lat;
                    q       <= '0;
                    qm      <= '1;
                    pre_en  <= 1'b0;
                    iter_en <= 1'b1;
                    state   <= ITER;
                end
                ITER: begin
                    q   <= q_nxt_c;
                    qm  <= qm_nxt_c;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        iter_en <= 1'b0;
                        post_en <= 1'b1;
                        state   <= POST;
                    end
                end
                POST: begin
                    quot         <= rem_neg_i ? qm : q;
                    post_en      <= 1'b0;
                    finish_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (bus.finish_ready_i) begin
                        finish_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    finish_valid <= 1'b0;
                    pre_en       <= 1'b0;
                    iter_en      <= 1'b0;
                    post_en      <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag malformed digits from the sign coder while iterating.
    always @(posedge clk) begin
        if (!rst && state == ITER) begin
            assert ($onehot(quot_dig_i))
            else $warning("radix_4_div_ctrl: non-one-hot quotient digit %b treated as 0", quot_dig_i);
        end
    end
`endif

endmodule

// File: tb/tb_radix_4_div_ctrl.sv
// Directed bench for radix_4_div_ctrl: an 8-bit instance for sequencing,
// handshake and reset behaviour, a 32-bit instance for count clamping.
module tb_radix_4_div_ctrl;
    localparam logic [4:0] DP2 = 5'b10000;
    localparam logic [4:0] DP1 = 5'b01000;
    localparam logic [4:0] D0  = 5'b00100;
    localparam logic [4:0] DM1 = 5'b00010;

    logic       clk;
    logic       rst;
    logic [4:0] dig8, dig32;
    logic       rn8, rn32;
    logic       pre8, iter8, post8;
    logic       pre32, iter32, post32;

    int checks;
    int failures;

    radix_4_div_ctrl_if #(.WIDTH(8),  .CNT_W(3)) bus8 ();
    radix_4_div_ctrl_if #(.WIDTH(32), .CNT_W(5)) bus32 ();

    radix_4_div_ctrl #(.WIDTH(8), .CNT_W(3)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave),
        .quot_dig_i(dig8), .rem_neg_i(rn8),
        .pre_en_o(pre8), .iter_en_o(iter8), .post_en_o(post8)
    );

    radix_4_div_ctrl #(.WIDTH(32), .CNT_W(5)) dut32 (
        .clk(clk), .rst(rst), .bus(bus32.slave),
        .quot_dig_i(dig32), .rem_neg_i(rn32),
        .pre_en_o(pre32), .iter_en_o(iter32), .post_en_o(post32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation on the 8-bit instance and follow it to DONE.
    task automatic run8(input logic [2:0] n, input logic dz, input logic rn,
                        input logic [4:0] digs [16],
                        output int lat, output int npre, output int niter, output int npost);
        int di;
        di = 0; lat = 1; npre = 0; niter = 0; npost = 0;
        bus8.start_valid_i = 1'b1;
        bus8.iter_num_i = n;
        bus8.divisor_is_zero_i = dz;
        rn8 = rn;
        step();
        bus8.start_valid_i = 1'b0;
        bus8.divisor_is_zero_i = 1'b0;
        while (bus8.finish_valid_o !== 1'b1 && lat < 64) begin
            if (pre8) npre++;
            if (post8) npost++;
            if (iter8) begin
                niter++;
                dig8 = digs[di];
                if (di < 15) di++;
            end
            step();
            lat++;
        end
        dig8 = D0;
    endtask

    task automatic run32(input logic [4:0] n, input logic [4:0] digs [16],
                         output int lat, output int niter);
        int di;
        di = 0; lat = 1; niter = 0;
        bus32.start_valid_i = 1'b1;
        bus32.iter_num_i = n;
        bus32.divisor_is_zero_i = 1'b0;
        rn32 = 1'b0;
        step();
        bus32.start_valid_i = 1'b0;
        while (bus32.finish_valid_o !== 1'b1 && lat < 64) begin
            if (iter32) begin
                niter++;
                dig32 = digs[di];
                if (di < 15) di++;
            end
            step();
            lat++;
        end
        dig32 = D0;
    endtask

    task automatic release8();
        bus8.finish_ready_i = 1'b1;
        step();
        bus8.finish_ready_i = 1'b0;
    endtask

    task automatic release32();
        bus32.finish_ready_i = 1'b1;
        step();
        bus32.finish_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus8.start_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_start_ready got=%b exp=1", bus8.start_ready_o);
        end
        checks++;
        if ({pre8, iter8, post8} !== 3'b000) begin
            failures++; $display("FAIL reset_enables got=%b exp=000", {pre8, iter8, post8});
        end
        checks++;
        if (bus8.finish_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_finish_valid got=%b exp=0", bus8.finish_valid_o);
        end
        checks++;
        if (bus8.quot_o !== 8'h00) begin
            failures++; $display("FAIL reset_quot got=%h exp=00", bus8.quot_o);
        end
        checks++;
        if (bus32.start_ready_o !== 1'b1 || bus32.quot_o !== 32'h0) begin
            failures++; $display("FAIL reset_wide got ready=%b quot=%h exp ready=1 quot=0",
                                 bus32.start_ready_o, bus32.quot_o);
        end
    endtask

    task automatic test_basic();
        logic [4:0] d [16];
        int lat, np, ni, npo;
        d = '{default: D0};
        d[0] = DP1; d[1] = DP2; d[2] = D0; d[3] = DM1;
        run8(3'd4, 1'b0, 1'b0, d, lat, np, ni, npo);
        checks++;
        if (lat != 7) begin
            failures++; $display("FAIL basic_latency got=%0d exp=7", lat);
        end
        checks++;
        if (ni != 4) begin
            failures++; $display("FAIL basic_iter_cycles got=%0d exp=4", ni);
        end
        checks++;
        if (bus8.quot_o !== 8'h5F) begin
            failures++; $display("FAIL basic_quot got=%h exp=5f", bus8.quot_o);
        end
        release8();
    endtask

    task automatic test_rem_neg();
        logic [4:0] d [16];
        int lat, np, ni, npo;
        d = '{default: D0};
        d[0] = DP1; d[1] = DP2; d[2] = D0; d[3] = DM1;
        run8(3'd4, 1'b0, 1'b1, d, lat, np, ni, npo);
        rn8 = 1'b0;
        checks++;
        if (bus8.quot_o !== 8'h5E) begin
            failures++; $display("FAIL remneg_quot got=%h exp=5e", bus8.quot_o);
        end
        checks++;
        if (np != 1 || ni != 4 || npo != 1) begin
            failures++; $display("FAIL remneg_pulses got pre=%0d iter=%0d post=%0d exp 1/4/1", np, ni, npo);
        end
        release8();
    endtask

    // Leaves the 8-bit instance waiting in DONE for test_hold.
    task automatic test_div_zero();
        logic [4:0] d [16];
        int lat, np, ni, npo;
        d = '{default: D0};
        run8(3'd4, 1'b1, 1'b0, d, lat, np, ni, npo);
        checks++;
        if (lat != 1) begin
            failures++; $display("FAIL divzero_latency got=%0d exp=1", lat);
        end
        checks++;
        if (bus8.quot_o !== 8'hFF) begin
            failures++; $display("FAIL divzero_quot got=%h exp=ff", bus8.quot_o);
        end
        checks++;
        if (np != 0 || ni != 0) begin
            failures++; $display("FAIL divzero_enables got pre=%0d iter=%0d exp 0/0", np, ni);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus8.finish_valid_o !== 1'b1 || bus8.quot_o !== 8'hFF || bus8.start_ready_o !== 1'b0) begin
                failures++; $display("FAIL hold_cycle%0d got fv=%b quot=%h rdy=%b exp fv=1 quot=ff rdy=0",
                                     i, bus8.finish_valid_o, bus8.quot_o, bus8.start_ready_o);
            end
        end
        bus8.start_valid_i = 1'b1;
        bus8.divisor_is_zero_i = 1'b1;
        bus8.iter_num_i = 3'd1;
        bus8.finish_ready_i = 1'b1;
        checks++;
        if (bus8.start_ready_o !== 1'b0) begin
            failures++; $display("FAIL hold_accept_cycle_ready got=%b exp=0", bus8.start_ready_o);
        end
        step();
        bus8.finish_ready_i = 1'b0;
        checks++;
        if (bus8.start_ready_o !== 1'b1 || bus8.finish_valid_o !== 1'b0) begin
            failures++; $display("FAIL hold_idle_bubble got rdy=%b fv=%b exp rdy=1 fv=0",
                                 bus8.start_ready_o, bus8.finish_valid_o);
        end
        step();
        bus8.start_valid_i = 1'b0;
        bus8.divisor_is_zero_i = 1'b0;
        checks++;
        if (bus8.finish_valid_o !== 1'b1 || bus8.start_ready_o !== 1'b0) begin
            failures++; $display("FAIL back_to_back_accept got fv=%b rdy=%b exp fv=1 rdy=0",
                                 bus8.finish_valid_o, bus8.start_ready_o);
        end
        release8();
    endtask

    task automatic test_reset_mid();
        logic [4:0] d [16];
        int lat, np, ni, npo;
        bus8.start_valid_i = 1'b1;
        bus8.iter_num_i = 3'd4;
        dig8 = DP1;
        step();
        bus8.start_valid_i = 1'b0;
        step();
        step();
        checks++;
        if (iter8 !== 1'b1) begin
            failures++; $display("FAIL midreset_in_iter got iter_en=%b exp=1", iter8);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus8.start_ready_o !== 1'b1 || {pre8, iter8, post8} !== 3'b000 ||
            bus8.finish_valid_o !== 1'b0 || bus8.quot_o !== 8'h00) begin
            failures++; $display("FAIL midreset_outputs got rdy=%b en=%b fv=%b quot=%h exp 1/000/0/00",
                                 bus8.start_ready_o, {pre8, iter8, post8}, bus8.finish_valid_o, bus8.quot_o);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (bus8.finish_valid_o !== 1'b0 || bus8.start_ready_o !== 1'b1) begin
            failures++; $display("FAIL midreset_discarded got fv=%b rdy=%b exp fv=0 rdy=1",
                                 bus8.finish_valid_o, bus8.start_ready_o);
        end
        d = '{default: D0};
        d[0] = DP2;
        run8(3'd1, 1'b0, 1'b0, d, lat, np, ni, npo);
        checks++;
        if (bus8.quot_o !== 8'h02 || lat != 4) begin
            failures++; $display("FAIL midreset_followup got quot=%h lat=%0d exp quot=02 lat=4", bus8.quot_o, lat);
        end
        release8();
    endtask

    task automatic test_wide();
        logic [4:0] d [16];
        int lat, ni;
        d = '{default: DP1};
        run32(5'd0, d, lat, ni);
        checks++;
        if (ni != 1 || lat != 4) begin
            failures++; $display("FAIL wide_zero_count got iter=%0d lat=%0d exp iter=1 lat=4", ni, lat);
        end
        checks++;
        if (bus32.quot_o !== 32'h0000_0001) begin
            failures++; $display("FAIL wide_zero_quot got=%h exp=00000001", bus32.quot_o);
        end
        release32();
        d[8] = 5'b00000;
        run32(5'd20, d, lat, ni);
        checks++;
        if (ni != 16 || lat != 19) begin
            failures++; $display("FAIL wide_sat_count got iter=%0d lat=%0d exp iter=16 lat=19", ni, lat);
        end
        checks++;
        if (bus32.quot_o !== 32'h5555_1555) begin
            failures++; $display("FAIL wide_bad_digit_quot got=%h exp=55551555", bus32.quot_o);
        end
        release32();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        dig8 = D0; dig32 = D0;
        rn8 = 1'b0; rn32 = 1'b0;
        bus8.start_valid_i = 1'b0; bus8.divisor_is_zero_i = 1'b0;
        bus8.iter_num_i = '0; bus8.finish_ready_i = 1'b0;
        bus32.start_valid_i = 1'b0; bus32.divisor_is_zero_i = 1'b0;
        bus32.iter_num_i = '0; bus32.finish_ready_i = 1'b0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_basic();
        test_rem_neg();
        test_div_zero();
        test_hold();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
